div: RTL

//  Iterative RV32M divider: DIV, DIVU, REM, REMU; the inverse of the combinational mul unit.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/div_step.sv | 20 ++
 rtl/div.sv | 120 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared execute-stage types: divider op encoding and FSM state, plus op-class helpers.
package decoder_pkg;

  typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  function automatic logic is_rem(div_op_t op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

  function automatic logic is_signed_op(div_op_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q
);
  logic [WIDTH:0] sh, diff;

  // The shifted remainder can reach 2*dvs-1, so compare in WIDTH+1 bits.
  always_comb begin
    sh      = {rem, dvd_bit};
    diff    = sh - {1'b0, dvs};
    q       = ~diff[WIDTH];
    rem_nxt = q ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle instead of WIDTH+2.
module div
  import decoder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  div_op_t          op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  div_op_t          op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, rem, sres;
  logic             neg_q, neg_r, spec_r;

  logic             sgn, a_neg, b_neg, div0, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res, rem_nxt, q_fix, r_fix;
  logic             q_bit;

  // Magnitudes fit WIDTH unsigned bits: |MIN_INT| = 2^(WIDTH-1).
  always_comb begin
    sgn      = is_signed_op(op);
    a_neg    = sgn & a[WIDTH-1];
    b_neg    = sgn & b[WIDTH-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    div0     = (b == '0);
    ovf      = sgn && (a == MIN_INT) && (b == '1);
    spec_res = div0 ? (is_rem(op) ? a : '1) : (is_rem(op) ? '0 : MIN_INT);
    q_fix    = neg_q ? (~dvd + 1'b1) : dvd;
    r_fix    = neg_r ? (~rem + 1'b1) : rem;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q       (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= '0;
      cnt    <= '0;
      op_r   <= DIV_DIV;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      sres   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      spec_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_r   <= op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dvd    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            cnt    <= CW'(WIDTH-1);
            spec_r <= div0 | ovf;
            sres   <= spec_res;
`ifdef DIV_FAST_SPECIAL_EN
            if (div0 | ovf) begin
              state <= DONE;
              done  <= 1'b1;
              res   <= spec_res;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          // Quotient bits shift in behind the dividend bits being consumed.
          dvd <= {dvd[WIDTH-2:0], q_bit};
          rem <= rem_nxt;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          res   <= spec_r ? sres : (is_rem(op_r) ? r_fix : q_fix);
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
